aes_decrypt_core: RTL and testbench
===================================

AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; only 10 is supported.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port AES_START  input  1  level request, driven from the start register.
REQ-005 SHALL have port AES_KEY  input  128  cipher key; [127:120] is key byte 0.
REQ-006 SHALL have port AES_MSG_ENC  input  128  ciphertext; [127:120] is state byte 0, column-major.
REQ-007 SHALL have port AES_MSG_DEC  output  128  plaintext result, same byte order.
REQ-008 SHALL have port AES_DONE  output  1  completion flag, feeds the done register.

Function
REQ-009 SHALL implement the FSM states IDLE, KEYEXP, ARK_INIT, INV_SHIFT, INV_SUB, ARK, INV_MIX and DONE.
REQ-010 SHALL, in IDLE with AES_START=1 at an edge (edge 0), capture AES_KEY and AES_MSG_ENC, clear the round counter, and enter KEYEXP.
REQ-011 SHALL, in KEYEXP, produce one round key per cycle into an 11x128 key store, writing keys 1..10 on edges 1..10, then enter ARK_INIT.
REQ-012 SHALL, in ARK_INIT, XOR the state with round key 10 (edge 11), then enter INV_SHIFT.
REQ-013 SHALL sequence the main rounds r=9..1 as INV_SHIFT -> INV_SUB -> ARK(key r) -> INV_MIX, one state per cycle (edges 12..47).
REQ-014 SHALL sequence the final round as INV_SHIFT -> INV_SUB -> ARK(key 0), skipping INV_MIX.
REQ-015 SHALL, on the final ARK edge (edge 50), load AES_MSG_DEC with the result and enter DONE, giving 50 edges from the start-sampling edge to AES_DONE=1.
REQ-016 SHALL drive AES_DONE=1 exactly while the FSM is in DONE, decoded from the state register and glitch-free.
REQ-017 SHALL hold DONE while AES_START=1 and return to IDLE on the first edge with AES_START=0.
REQ-018 SHALL ignore AES_START deassertion mid-operation: the operation always runs to DONE.
REQ-019 SHALL ignore changes on AES_KEY and AES_MSG_ENC after edge 0.
REQ-020 SHALL hold AES_MSG_DEC at its last value from edge 0 until the final ARK edge of the next operation, with no intermediate values visible.
REQ-021 SHALL keep a 4-bit round counter with a decrement per INV_MIX; the counter SHALL never wrap, and values outside 0..10 are unreachable.
REQ-022 SHALL, with AES_START held high continuously, perform exactly one operation; a new one requires AES_START low for at least one edge.

Reset
REQ-023 SHALL, while RESET_N=0, force FSM=IDLE, AES_DONE=0, AES_MSG_DEC=0, round counter=0, and the state and captured-key registers to 0, independent of CLK.
REQ-024 SHALL abort an in-flight operation on reset with no partial result on AES_MSG_DEC.
REQ-025 SHALL start a new operation no earlier than the first edge after RESET_N rises.
REQ-026 SHALL not reset the key store; it is always rewritten before use.

Structure
REQ-027 SHALL place the FSM state enum, the Rcon[1..10] constant table and NR in shared package aes_pkg.
REQ-028 SHALL use one sub-module, aes_key_step: a combinational next-round-key function (prev key, Rcon) -> next key, containing RotWord/SubWord/XOR chain.
REQ-029 SHALL reuse the team's existing byte S-box, inverse S-box and InvMixColumns column modules; it SHALL not duplicate the tables.
REQ-030 SHALL keep one 128-bit state register with a mux selecting among the four transform outputs.

Verification
REQ-031 SHALL cover this case: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, START=1 -> AES_DONE rises 50 edges later, AES_MSG_DEC=00112233445566778899aabbccddeeff.
REQ-032 SHALL cover this case: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> AES_MSG_DEC=3243f6a8885a308d313198a2e0370734.
REQ-033 SHALL cover this case: change AES_KEY/AES_MSG_ENC to ffff... at edge 5 of the first vector -> result still 0011...eeff.
REQ-034 SHALL cover this case: drop RESET_N at edge 20 of an operation -> AES_DONE=0 and AES_MSG_DEC=0 immediately; after release, FSM=IDLE and a fresh vector decrypts correctly.
REQ-035 SHALL cover this case: hold START=1 for 200 cycles -> exactly one AES_DONE rise; AES_DONE falls one edge after START=0, and back-to-back vector 2 then succeeds.
REQ-036 SHALL cover this case: deassert START at edge 10 -> AES_DONE still rises at edge 50 with the correct result, and the FSM then returns to IDLE on the next edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 decrypt definitions: FSM states, round constants and GF(2^8) helpers
// used by the S-box and InvMixColumns building blocks.
package aes_pkg;
    localparam int NR = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYEXP,
        S_ARK_INIT,
        S_INV_SHIFT,
        S_INV_SUB,
        S_ARK,
        S_INV_MIX,
        S_DONE
    } state_e;

    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction
endpackage

// File: rtl/aes_inv_mixcol.sv
// InvMixColumns on one 32-bit column (block library); row 0 in [31:24].
module aes_inv_mixcol (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    import aes_pkg::*;

    logic [7:0] b0, b1, b2, b3;

    assign {b0, b1, b2, b3} = col_in;

    assign col_out[31:24] = gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09);
    assign col_out[23:16] = gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d);
    assign col_out[15:8]  = gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b);
    assign col_out[7:0]   = gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e);
endmodule

// File: rtl/aes_inv_sbox.sv
// Inverse AES byte S-box (block library).
module aes_inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    import aes_pkg::*;

    assign dout = gf_inv(inv_affine(din));
endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: previous round key plus Rcon -> next round key.
module aes_key_step (
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, tmp_w;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (.din(rot_w[8*b +: 8]), .dout(sub_w[8*b +: 8]));
    end

    assign tmp_w = sub_w ^ {rcon, 24'h0};
    assign n0 = w0 ^ tmp_w;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_sbox.sv
// Forward AES byte S-box (block library), computed from the field inverse.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    import aes_pkg::*;

    assign dout = sbox_affine(gf_inv(din));
endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: expands keys once per operation, then walks the inverse
// rounds one transform per cycle through a single state register.
module aes_decrypt_core #(
    parameter int NR = aes_pkg::NR
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         AES_START,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_ENC,
    output logic [127:0] AES_MSG_DEC,
    output logic         AES_DONE
);
    import aes_pkg::*;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] key_q, key_d;
    logic [127:0] dec_q, dec_d;
    logic         done_q;
    logic         ks_we;
    logic [127:0] ks_q [1:NR];

    logic [3:0]   rd_idx;
    logic [127:0] rd_key, key_next, ark_out, shift_out, sub_out, mix_out;
    logic [7:0]   rcon_sel;

    // Key 0 lives in the resettable capture register; keys 1..NR in the store
    always_comb begin
        rd_idx = (state_q == S_ARK) ? cnt_q - 4'd1 : cnt_q;
        rd_key = key_q;
        for (int i = 1; i <= NR; i++)
            if (rd_idx == 4'(i)) rd_key = ks_q[i];
    end

    assign ark_out  = st_q ^ rd_key;
    assign rcon_sel = (cnt_q < 4'(NR)) ? RCON[cnt_q + 4'd1] : 8'h00;

    aes_key_step u_key_step (.prev_key(rd_key), .rcon(rcon_sel), .next_key(key_next));

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shift_out[127 - 8*(4*c + r) -: 8] = st_q[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            aes_inv_sbox u_isbox (.din(st_q[127 - 8*(4*c + r) -: 8]), .dout(sub_out[127 - 8*(4*c + r) -: 8]));
        end
        aes_inv_mixcol u_imix (.col_in(st_q[127 - 32*c -: 32]), .col_out(mix_out[127 - 32*c -: 32]));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            key_q   <= '0;
            dec_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            done_q  <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge CLK) begin
        if (ks_we)
            for (int i = 1; i <= NR; i++)
                if (cnt_q == 4'(i - 1)) ks_q[i] <= key_next;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (AES_START) state_d = S_KEYEXP;
            S_KEYEXP:    if (cnt_q == 4'(NR - 1)) state_d = S_ARK_INIT;
            S_ARK_INIT:  state_d = S_INV_SHIFT;
            S_INV_SHIFT: state_d = S_INV_SUB;
            S_INV_SUB:   state_d = S_ARK;
            S_ARK:       state_d = (cnt_q == 4'd1) ? S_DONE : S_INV_MIX;
            S_INV_MIX:   state_d = S_INV_SHIFT;
            S_DONE:      if (!AES_START) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Counter climbs to NR during expansion, then each INV_MIX steps it down to 1
    always_comb begin
        cnt_d = cnt_q;
        st_d  = st_q;
        key_d = key_q;
        dec_d = dec_q;
        ks_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (AES_START) begin
                    key_d = AES_KEY;
                    st_d  = AES_MSG_ENC;
                    cnt_d = '0;
                end
            end
            S_KEYEXP: begin
                ks_we = 1'b1;
                cnt_d = cnt_q + 4'd1;
            end
            S_ARK_INIT:  st_d = ark_out;
            S_INV_SHIFT: st_d = shift_out;
            S_INV_SUB:   st_d = sub_out;
            S_ARK: begin
                st_d = ark_out;
                if (cnt_q == 4'd1) dec_d = ark_out;
            end
            S_INV_MIX: begin
                st_d  = mix_out;
                cnt_d = cnt_q - 4'd1;
            end
            default: ;
        endcase
    end

    assign AES_MSG_DEC = dec_q;
    assign AES_DONE    = done_q;
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Scenario bench for aes_decrypt_core: FIPS-197 vectors, reset abort, START handling.
module tb_aes_decrypt_core;
    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         AES_START;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_ENC;
    logic [127:0] AES_MSG_DEC;
    logic         AES_DONE;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_core #(.NR(10)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .AES_START(AES_START), .AES_KEY(AES_KEY),
        .AES_MSG_ENC(AES_MSG_ENC), .AES_MSG_DEC(AES_MSG_DEC), .AES_DONE(AES_DONE)
    );

    always #5 CLK = ~CLK;

    // Called at a negedge; the following posedge is edge 0
    task automatic start_op(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
        AES_KEY = k;
        AES_MSG_ENC = ct;
        AES_START = 1'b1;
        exp_q.push_back(pt);
    endtask

    // Returns the edge index at which AES_DONE was first seen (-1 on timeout) and whether
    // AES_MSG_DEC stayed at its entry value until then.
    task automatic wait_done(input int drop_edge, input int chg_edge, output int lat, output bit held);
        logic [127:0] dec0;
        dec0 = AES_MSG_DEC;
        lat = -1;
        held = 1'b1;
        for (int e = 0; e <= 100; e++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (AES_DONE) begin
                lat = e;
                break;
            end
            if (AES_MSG_DEC !== dec0) held = 1'b0;
            if (e == drop_edge) AES_START = 1'b0;
            if (e == chg_edge) begin
                AES_KEY = '1;
                AES_MSG_ENC = '1;
            end
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        AES_START = 1'b0;
        AES_KEY = '0;
        AES_MSG_ENC = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if (AES_DONE !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", AES_DONE); end
        checks++;
        if (AES_MSG_DEC !== '0) begin failures++; $display("FAIL reset_dec: got %h want 0", AES_MSG_DEC); end
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic run_vector(input string name, input logic [127:0] k, input logic [127:0] ct,
                              input logic [127:0] pt);
        int lat;
        bit held;
        logic [127:0] exp;
        start_op(k, ct, pt);
        wait_done(-1, -1, lat, held);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 50) begin failures++; $display("FAIL %s_latency: got %0d want 50", name, lat); end
        checks++;
        if (AES_MSG_DEC !== exp) begin failures++; $display("FAIL %s_result: got %h want %h", name, AES_MSG_DEC, exp); end
        checks++;
        if (held !== 1'b1) begin failures++; $display("FAIL %s_dec_held: got %b want 1", name, held); end
        AES_START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (AES_DONE !== 1'b0) begin failures++; $display("FAIL %s_done_fall: got %b want 0", name, AES_DONE); end
    endtask

    task automatic test_input_change();
        int lat;
        bit held;
        logic [127:0] exp;
        start_op(K1, C1, P1);
        wait_done(-1, 4, lat, held);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 50) begin failures++; $display("FAIL chg_latency: got %0d want 50", lat); end
        checks++;
        if (AES_MSG_DEC !== exp) begin failures++; $display("FAIL chg_result: got %h want %h", AES_MSG_DEC, exp); end
        AES_START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        bit quiet;
        start_op(K1, C1, P1);
        repeat (21) @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (AES_DONE !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b want 0", AES_DONE); end
        checks++;
        if (AES_MSG_DEC !== '0) begin failures++; $display("FAIL rstmid_dec: got %h want 0", AES_MSG_DEC); end
        exp_q.delete();
        AES_START = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        quiet = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
            if (AES_DONE !== 1'b0 || AES_MSG_DEC !== '0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin failures++; $display("FAIL rstmid_idle_quiet: got %b want 1", quiet); end
        run_vector("rstmid_fresh", K2, C2, P2);
    endtask

    task automatic test_hold_start();
        int lat;
        bit held;
        int rises;
        logic prev;
        logic [127:0] exp;
        start_op(K1, C1, P1);
        wait_done(-1, -1, lat, held);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 50) begin failures++; $display("FAIL hold_latency: got %0d want 50", lat); end
        checks++;
        if (AES_MSG_DEC !== exp) begin failures++; $display("FAIL hold_result: got %h want %h", AES_MSG_DEC, exp); end
        rises = (lat >= 0) ? 1 : 0;
        prev = AES_DONE;
        for (int i = 51; i < 200; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (AES_DONE && !prev) rises++;
            prev = AES_DONE;
        end
        checks++;
        if (rises !== 1) begin failures++; $display("FAIL hold_rises: got %0d want 1", rises); end
        checks++;
        if (AES_DONE !== 1'b1) begin failures++; $display("FAIL hold_done_kept: got %b want 1", AES_DONE); end
        AES_START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (AES_DONE !== 1'b0) begin failures++; $display("FAIL hold_done_fall: got %b want 0", AES_DONE); end
        run_vector("b2b_vec2", K2, C2, P2);
    endtask

    task automatic test_early_release();
        int lat;
        bit held;
        logic [127:0] exp;
        start_op(K1, C1, P1);
        wait_done(10, -1, lat, held);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 50) begin failures++; $display("FAIL early_latency: got %0d want 50", lat); end
        checks++;
        if (AES_MSG_DEC !== exp) begin failures++; $display("FAIL early_result: got %h want %h", AES_MSG_DEC, exp); end
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (AES_DONE !== 1'b0) begin failures++; $display("FAIL early_to_idle: got %b want 0", AES_DONE); end
        repeat (3) @(negedge CLK);
        checks++;
        if (AES_DONE !== 1'b0 || AES_MSG_DEC !== exp) begin
            failures++;
            $display("FAIL early_idle_hold: done %b dec %h want 0 / %h", AES_DONE, AES_MSG_DEC, exp);
        end
    endtask

    initial begin
        test_reset();
        run_vector("vec1", K1, C1, P1);
        run_vector("vec2", K2, C2, P2);
        test_input_change();
        test_reset_mid();
        test_hold_start();
        test_early_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
